// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Instruction fetch stage with PC, IR, redirect/squash and
//            start/halt/done run control.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int              PCW        = 10,
    parameter int              IW         = 9,
    parameter logic [PCW-1:0]  START_ADDR = '0,
    parameter logic [IW-1:0]   HALT       = 9'b110_000000
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Start,
    input  logic [IW-1:0]  Instr_i,
    input  logic           Branch,
    input  logic           Jump,
    input  logic           Zero,
    input  logic [PCW-1:0] Target,
    output logic [PCW-1:0] PC,
    output logic [IW-1:0]  Instr,
    output logic [2:0]     Opcode,
    output logic [1:0]     Func,
    output logic           Valid,
    output logic           Done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PCW-1:0]  r_pc;
    logic [PCW-1:0]  w_pc_nxt;
    logic [IW-1:0]   r_ir;
    logic [IW-1:0]   w_ir_nxt;
    logic            r_valid;
    logic            w_valid_nxt;
    logic            r_done;
    logic            w_done_nxt;
    logic            w_halt;
    logic            w_redirect;

    // Decoder feedback only counts for a real instruction; the squashed slot is inert.
    assign w_halt     = r_valid && (r_ir == HALT);
    assign w_redirect = r_valid && (Jump || (Branch && Zero));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_pc    <= START_ADDR;
            r_ir    <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_valid_nxt = r_valid;
        w_done_nxt  = r_done;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = START_ADDR;
                    w_valid_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                end
            end
            S_RUN: begin
                w_ir_nxt = Instr_i;
                // HALT decodes as a jump opcode, so it must win over the redirect.
                if (w_halt) begin
                    w_state_nxt = S_DONE;
                    w_valid_nxt = 1'b0;
                    w_done_nxt  = 1'b1;
                end else if (w_redirect) begin
                    w_pc_nxt    = Target;
                    w_valid_nxt = 1'b0;
                end else begin
                    w_pc_nxt    = r_pc + 1'b1;
                    w_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign PC     = r_pc;
    assign Instr  = r_ir;
    assign Opcode = r_ir[IW-1 -: 3];
    assign Func   = r_ir[1:0];
    assign Valid  = r_valid;
    assign Done   = r_done;

endmodule
`default_nettype wire
